// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host/transmitter handshake bundle for uart_tx_feeder
interface uart_tx_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_en;
  logic          feeder_en;
  logic          TX_BUSY;
  logic [7:0]    Tx_DATA;
  logic          Tx_WR;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          timeout_err;

  modport slave (
    input  wr_data, wr_en, feeder_en, TX_BUSY,
    output Tx_DATA, Tx_WR, fifo_full, fifo_empty, fifo_count, overflow, timeout_err
  );

  modport master (
    output wr_data, wr_en, feeder_en, TX_BUSY,
    input  Tx_DATA, Tx_WR, fifo_full, fifo_empty, fifo_count, overflow, timeout_err
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO feeding uart_transmitter over Tx_DATA/Tx_WR/TX_BUSY
module uart_tx_feeder #(
  parameter int DEPTH        = 8,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_feeder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_tx_data;
  logic          r_tx_wr;
  logic          r_overflow;
  logic          r_timeout_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_timeout;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign w_push  = bus.wr_en & ~w_full;
  assign w_pop   = (r_state == LOAD) & ~w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.feeder_en && !w_empty && !bus.TX_BUSY) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.TX_BUSY) begin
          w_next = WAIT_LO;
        end else if (r_timer == TW'(WAIT_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      WAIT_LO: begin
        if (!bus.TX_BUSY) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_timer       <= '0;
      r_tx_data     <= 8'h00;
      r_tx_wr       <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_tx_wr <= w_pop;
      if (r_state == LOAD) begin
        r_timer <= '0;
      end else if (r_state == WAIT_HI) begin
        r_timer <= r_timer + TW'(1);
      end
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.Tx_DATA     = r_tx_data;
  assign bus.Tx_WR       = r_tx_wr;
  assign bus.fifo_full   = w_full;
  assign bus.fifo_empty  = w_empty;
  assign bus.fifo_count  = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_tx_feeder_if #(.DEPTH(8)) bus ();

  uart_tx_feeder #(.DEPTH(8), .WAIT_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transmitter model: goes busy for busy_len cycles after each Tx_WR (tx_mode=1) or stays idle (tx_mode=0).
  logic       tx_busy   = 1'b0;
  logic [7:0] rx_q [$];
  int         wide_err  = 0;
  bit         prev_wr   = 1'b0;
  int         busy_cnt  = 0;
  bit         tx_mode   = 1'b1;
  int         busy_len  = 10;

  assign bus.TX_BUSY = tx_busy;

  always @(negedge clk) begin
    if (bus.Tx_WR === 1'b1) begin
      rx_q.push_back(bus.Tx_DATA);
      if (prev_wr) wide_err++;
      if (tx_mode) busy_cnt = busy_len;
    end
    prev_wr = (bus.Tx_WR === 1'b1);
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       fen;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (bus.fifo_empty && !tx_busy && !bus.Tx_WR) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check("drain_timeout", 32'(n), 32'(max_cycles + 1));
  endtask

  initial begin
    int base;

    for (int i = 0; i < 9; i++) begin
      vecs[i].wr_en = 1'b1;
      vecs[i].data  = 8'(8'h30 + i);
      vecs[i].fen   = 1'b0;
      vecs[i].cnt   = (i < 8) ? 4'(i + 1) : 4'd8;
      vecs[i].full  = (i >= 7);
      vecs[i].empty = 1'b0;
      vecs[i].ovf   = (i == 8);
    end
    vecs[9] = '{wr_en: 1'b0, data: 8'h00, fen: 1'b0, cnt: 4'd8, full: 1'b1, empty: 1'b0, ovf: 1'b1};

    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.feeder_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx_wr",   32'(bus.Tx_WR),       32'd0);
    check("rst_tx_data", 32'(bus.Tx_DATA),     32'h00);
    check("rst_empty",   32'(bus.fifo_empty),  32'd1);
    check("rst_full",    32'(bus.fifo_full),   32'd0);
    check("rst_count",   32'(bus.fifo_count),  32'd0);
    check("rst_ovf",     32'(bus.overflow),    32'd0);
    check("rst_tmo",     32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte and E+2 latency
    tx_mode = 1'b1;
    busy_len = 10;
    bus.feeder_en = 1'b1;
    base = rx_q.size();
    push(8'hDD);
    check("lat_e1_wr", 32'(bus.Tx_WR), 32'd0);
    @(negedge clk);
    check("lat_e2m_wr", 32'(bus.Tx_WR), 32'd0);
    @(negedge clk);
    check("lat_e2_wr",   32'(bus.Tx_WR),      32'd1);
    check("lat_e2_data", 32'(bus.Tx_DATA),    32'hDD);
    check("lat_e2_cnt",  32'(bus.fifo_count), 32'd0);
    @(negedge clk);
    check("lat_e3_wr",   32'(bus.Tx_WR),   32'd0);
    check("lat_e3_data", 32'(bus.Tx_DATA), 32'hDD);
    drain(60);
    check("single_empty", 32'(bus.fifo_empty),     32'd1);
    check("single_n",     32'(rx_q.size() - base), 32'd1);
    check("single_byte",  32'(rx_q[base]),         32'hDD);

    // Burst across pointer wrap
    busy_len = 3;
    base = rx_q.size();
    for (int i = 1; i <= 4; i++) push(8'(i));
    drain(200);
    for (int i = 5; i <= 10; i++) push(8'(i));
    drain(200);
    for (int i = 11; i <= 12; i++) push(8'(i));
    drain(200);
    check("burst_n", 32'(rx_q.size() - base), 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("burst_b%0d", i), 32'(rx_q[base + i]), 32'(i + 1));

    // Push and pop on the same edge at count=3
    bus.feeder_en = 1'b0;
    base = rx_q.size();
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("sim_cnt0", 32'(bus.fifo_count), 32'd3);
    bus.feeder_en = 1'b1;
    @(negedge clk);
    check("sim_cnt_load", 32'(bus.fifo_count), 32'd3);
    push(8'h44);
    check("sim_cnt_pp", 32'(bus.fifo_count), 32'd3);
    check("sim_wr",     32'(bus.Tx_WR),      32'd1);
    check("sim_data",   32'(bus.Tx_DATA),    32'h41);
    drain(200);
    check("sim_n", 32'(rx_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("sim_b%0d", i), 32'(rx_q[base + i]), 32'(8'h41 + i));

    // Overflow, table driven with feeder disabled
    base = rx_q.size();
    for (int i = 0; i < 10; i++) begin
      bus.wr_en     = vecs[i].wr_en;
      bus.wr_data   = vecs[i].data;
      bus.feeder_en = vecs[i].fen;
      @(negedge clk);
      check($sformatf("ovf_v%0d_cnt", i),   32'(bus.fifo_count), 32'(vecs[i].cnt));
      check($sformatf("ovf_v%0d_full", i),  32'(bus.fifo_full),  32'(vecs[i].full));
      check($sformatf("ovf_v%0d_empty", i), 32'(bus.fifo_empty), 32'(vecs[i].empty));
      check($sformatf("ovf_v%0d_ovf", i),   32'(bus.overflow),   32'(vecs[i].ovf));
    end
    bus.wr_en = 1'b0;
    bus.feeder_en = 1'b1;
    drain(300);
    check("ovf_n",      32'(rx_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("ovf_b%0d", i), 32'(rx_q[base + i]), 32'(8'h30 + i));
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Timeout with TX_BUSY never rising
    tx_mode = 1'b0;
    base = rx_q.size();
    push(8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("tmo_wr",   32'(bus.Tx_WR),   32'd1);
    check("tmo_data", 32'(bus.Tx_DATA), 32'hA5);
    repeat (254) @(negedge clk);
    check("tmo_early", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    check("tmo_set",   32'(bus.timeout_err), 32'd1);
    repeat (3) @(negedge clk);
    check("tmo_n",     32'(rx_q.size() - base), 32'd1);
    check("tmo_empty", 32'(bus.fifo_empty),     32'd1);
    push(8'h5A);
    @(negedge clk);
    @(negedge clk);
    check("tmo_idle_wr",   32'(bus.Tx_WR),   32'd1);
    check("tmo_idle_data", 32'(bus.Tx_DATA), 32'h5A);

    // Reset in the middle of a handshake
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_mode = 1'b1;
    busy_len = 10;
    @(negedge clk);
    check("rst2_tmo", 32'(bus.timeout_err), 32'd0);
    check("rst2_ovf", 32'(bus.overflow),    32'd0);
    push(8'h71);
    push(8'h72);
    push(8'h73);
    check("mid_wr", 32'(bus.Tx_WR), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_wr",    32'(bus.Tx_WR),      32'd0);
    check("mid_rst_cnt",   32'(bus.fifo_count), 32'd0);
    check("mid_rst_empty", 32'(bus.fifo_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_cnt", 32'(bus.fifo_count), 32'd0);
    check("post_rst_wr",  32'(bus.Tx_WR),      32'd0);

    check("wr_one_cycle", 32'(wide_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Purpose: buffered byte source sitting directly upstream of uart_transmitter; queues host bytes and hands them one at a time to the transmitter over its Tx_DATA / Tx_WR / TX_BUSY handshake.

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes (power of two).
REQ-002 Parameter WAIT_TIMEOUT, default 255, max cycles to wait for TX_BUSY rise after a Tx_WR pulse.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high, with the ports named clk and reset as in the rest of the codebase.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 wr_en  input  1  enqueue strobe, sampled on each rising edge.
REQ-008 feeder_en  input  1  permits launching new bytes to the transmitter.
REQ-009 TX_BUSY  input  1  transmitter busy, from uart_transmitter.
REQ-010 Tx_DATA  output  8  byte presented to the transmitter, registered.
REQ-011 Tx_WR  output  1  one-cycle load pulse to the transmitter, registered.
REQ-012 fifo_full  output  1  count == DEPTH.
REQ-013 fifo_empty  output  1  count == 0.
REQ-014 fifo_count  output  log2(DEPTH)+1  bytes stored, 0..DEPTH.
REQ-015 overflow  output  1  sticky: a write was dropped.
REQ-016 timeout_err  output  1  sticky: TX_BUSY failed to rise within WAIT_TIMEOUT cycles.

Function
REQ-017 FIFO: circular buffer, read/write pointers log2(DEPTH) bits, wrapping from DEPTH-1 to 0; fifo_full/fifo_empty/fifo_count derived from registered count.
REQ-018 Push: wr_en=1 and fifo_full=0 at the edge -> store wr_data, count+1.
REQ-019 wr_en=1 while fifo_full=1 -> byte discarded, overflow set to 1 until reset, even if a pop occurs on the same edge.
REQ-020 Simultaneous push and pop with count between 1 and DEPTH-1 -> both performed, count unchanged.
REQ-021 Pop occurs only in state LOAD; never when count is 0.
REQ-022 FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO.
REQ-023 IDLE -> LOAD when feeder_en=1, fifo_empty=0 and TX_BUSY=0; otherwise stay.
REQ-024 LOAD: on the next edge, Tx_DATA <= head byte, pop, Tx_WR <= 1, timer cleared, go to WAIT_HI.
REQ-025 Tx_WR SHALL be high for exactly one clock cycle per transmitted byte.
REQ-026 WAIT_HI: TX_BUSY=1 -> WAIT_LO; timer reaching WAIT_TIMEOUT -> set timeout_err, go to IDLE.
REQ-027 WAIT_LO: TX_BUSY=0 -> IDLE.
REQ-028 Tx_DATA holds its value from the LOAD edge until the next LOAD edge.
REQ-029 Latency: byte pushed at edge E into an empty FIFO with FSM in IDLE, feeder_en=1 and TX_BUSY=0 -> Tx_DATA valid and Tx_WR=1 from edge E+2 to edge E+3.
REQ-030 feeder_en deasserted mid-byte -> current handshake completes to IDLE; no new LOAD until feeder_en=1.
REQ-031 Bytes SHALL leave in strict write order; none duplicated or skipped, including across pointer wrap.

Reset
REQ-032 reset=1 asynchronously clears: state=IDLE, pointers=0, count=0, Tx_DATA=8'h00, Tx_WR=0, overflow=0, timeout_err=0; fifo_empty=1, fifo_full=0.
REQ-033 Reset asserted mid-handshake -> Tx_WR low immediately (no clock needed); queued bytes lost.
REQ-034 FIFO storage array contents need not be reset.

Verification
REQ-035 Single byte: reset, push 8'hDD with transmitter model busy for 10 cycles after Tx_WR -> Tx_WR pulse 1 cycle at E+2, Tx_DATA=8'hDD, fifo_empty=1 after.
REQ-036 Burst/wrap: push 8'h01..8'h0C in three batches interleaved with drains -> transmitter receives 8'h01..8'h0C in order, exactly one Tx_WR each.
REQ-037 Overflow: feeder_en=0, push 9 bytes -> fifo_full=1, fifo_count=8, overflow=1, 9th byte never transmitted.
REQ-038 Timeout: TX_BUSY tied 0, push 8'hA5 -> one Tx_WR, timeout_err=1 after 255 cycles in WAIT_HI, FSM back to IDLE.
REQ-039 Reset mid-byte: assert reset while Tx_WR=1 -> Tx_WR=0 and fifo_count=0 before next clk edge.
REQ-040 Simultaneous push/pop at count=3 -> fifo_count stays 3.
